// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller: tracks in-flight producers past X, selects
// operand forwarding sources, stalls on load-use, kills wrong-path fetch, freezes on mem_busy.
module hazard_fwd_unit #(
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned LOAD_LAT      = 1,
  parameter int unsigned FLUSH_BUBBLES = 1,
  parameter int unsigned SELW          = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_x,
  input  logic            x_valid,
  input  logic            x_redirect,
  input  logic            mem_busy,
  output logic            stall,
  output logic            bubble,
  output logic            kill_fd,
  output logic [SELW-1:0] fwd_a,
  output logic [SELW-1:0] fwd_b,
  output logic [31:0]     stall_cycles
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t     state;
  logic [2:0] cnt;

  logic [DEPTH-1:0] slot_v;
  logic [DEPTH-1:0] slot_ld;
  logic [4:0]       slot_rd [DEPTH];

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic       prod, is_load, rs1_used, rs2_used;
  logic       lu_a, lu_b, accept;
  logic       unused_bits;

  assign opcode      = inst_x[6:0];
  assign rd          = inst_x[11:7];
  assign rs1         = inst_x[19:15];
  assign rs2         = inst_x[24:20];
  assign unused_bits = ^{inst_x[31:25], inst_x[14:12]};

  always_comb begin
    prod     = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    unique case (opcode)
      7'h33:               begin prod = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
      7'h13, 7'h03, 7'h67,
      7'h73:               begin prod = 1'b1; rs1_used = 1'b1; end
      7'h23, 7'h63:        begin rs1_used = 1'b1; rs2_used = 1'b1; end
      7'h37, 7'h17, 7'h6F: prod = 1'b1;
      default: ;
    endcase
    prod    = prod && x_valid && (rd != 5'd0);
    is_load = (opcode == 7'h03);
  end

  // Returns {load_use, select}; youngest matching slot wins.
  function automatic logic [SELW:0] search(input logic [4:0] rs, input logic used);
    logic [SELW-1:0] sel;
    logic            lu;
    logic            found;
    sel   = '0;
    lu    = 1'b0;
    found = 1'b0;
    if (used && x_valid && rs != 5'd0) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (!found && slot_v[i] && slot_rd[i] == rs) begin
          found = 1'b1;
          sel   = SELW'(i + 1);
          lu    = slot_ld[i] && (i < LOAD_LAT);
        end
      end
    end
    return {lu, sel};
  endfunction

  always_comb begin
    {lu_a, fwd_a} = search(rs1, rs1_used);
    {lu_b, fwd_b} = search(rs2, rs2_used);
    stall   = lu_a | lu_b;
    bubble  = stall & ~mem_busy;
    accept  = x_redirect & ~stall & ~mem_busy;
    kill_fd = (state == FLUSH) | accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_v       <= '0;
      slot_ld      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) slot_rd[i] <= '0;
      state        <= RUN;
      cnt          <= '0;
      stall_cycles <= '0;
    end else if (!mem_busy) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        slot_v[i]  <= slot_v[i-1];
        slot_ld[i] <= slot_ld[i-1];
        slot_rd[i] <= slot_rd[i-1];
      end
      slot_v[0]  <= prod & ~stall;
      slot_ld[0] <= is_load;
      slot_rd[0] <= rd;

      if (stall) begin
        if (stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
        if (state == RUN) state <= STALL;
      end else if (accept) begin
        // The accept cycle itself is the first kill cycle, so FLUSH covers the rest.
        if (FLUSH_BUBBLES <= 1) begin
          state <= RUN;
          cnt   <= '0;
        end else begin
          state <= FLUSH;
          cnt   <= 3'(FLUSH_BUBBLES - 1);
        end
      end else begin
        unique case (state)
          STALL: state <= RUN;
          FLUSH: begin
            if (cnt <= 3'd1) begin
              state <= RUN;
              cnt   <= '0;
            end else begin
              cnt <= cnt - 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed scenarios plus randomized traffic checked
// against a queue-based model of the producer history.
module tb_hazard_fwd_unit;

  localparam int DEPTH = 2;
  localparam int LOAD_LAT = 1;
  localparam int FB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_x;
  logic        x_valid, x_redirect, mem_busy;
  logic        stall, bubble, kill_fd;
  logic [2:0]  fwd_a, fwd_b;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  hazard_fwd_unit #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FLUSH_BUBBLES(FB), .SELW(3)) dut (
    .clk(clk), .rst(rst), .inst_x(inst_x), .x_valid(x_valid), .x_redirect(x_redirect),
    .mem_busy(mem_busy), .stall(stall), .bubble(bubble), .kill_fd(kill_fd),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; bit [4:0] rd; bit ld; } prod_t;
  prod_t       hist[$];
  int          kills_left;
  longint      m_count;
  bit          e_stall, e_bubble, e_kill;
  int          e_fa, e_fb;

  function automatic [31:0] r_type(input [4:0] rd, input [4:0] a, input [4:0] b, input bit sub);
    r_type = {sub ? 7'h20 : 7'h00, b, a, 3'b000, rd, 7'h33};
  endfunction
  function automatic [31:0] addi(input [4:0] rd, input [4:0] a, input [11:0] imm);
    addi = {imm, a, 3'b000, rd, 7'h13};
  endfunction
  function automatic [31:0] lw(input [4:0] rd, input [4:0] a);
    lw = {12'd0, a, 3'b010, rd, 7'h03};
  endfunction

  function automatic int find_src(input [4:0] rs, input bit used, output bit lu);
    lu = 1'b0;
    if (!x_valid || !used || rs == 0) return 0;
    foreach (hist[i]) if (hist[i].v && hist[i].rd == rs) begin
      lu = hist[i].ld && (i < LOAD_LAT);
      return i + 1;
    end
    return 0;
  endfunction

  task automatic model_eval();
    bit [6:0] op;
    bit u1, u2, la, lb;
    op = inst_x[6:0];
    u1 = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h73};
    u2 = op inside {7'h33, 7'h23, 7'h63};
    e_fa = find_src(inst_x[19:15], u1, la);
    e_fb = find_src(inst_x[24:20], u2, lb);
    e_stall  = la || lb;
    e_bubble = e_stall && !mem_busy;
    e_kill   = (kills_left > 0) || (x_redirect && !e_stall && !mem_busy);
  endtask

  task automatic model_commit();
    prod_t p;
    bit [6:0] op;
    bit accept;
    if (mem_busy) return;
    op = inst_x[6:0];
    accept = x_redirect && !e_stall;
    p.v  = !e_stall && x_valid && inst_x[11:7] != 0 &&
           (op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73});
    p.rd = inst_x[11:7];
    p.ld = (op == 7'h03);
    hist.push_front(p);
    void'(hist.pop_back());
    if (e_stall) begin
      if (m_count < 64'hFFFF_FFFF) m_count++;
    end else if (accept) kills_left = FB - 1;
    else if (kills_left > 0) kills_left--;
  endtask

  task automatic apply(input [31:0] inst, input bit v, input bit redir, input bit busy);
    inst_x = inst; x_valid = v; x_redirect = redir; mem_busy = busy;
    model_eval();
    @(negedge clk);
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    prod_t z;
    rst = 1'b1; inst_x = '0; x_valid = 1'b0; x_redirect = 1'b0; mem_busy = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    z.v = 0; z.rd = 0; z.ld = 0;
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back(z);
    kills_left = 0;
    m_count = 0;
  endtask

  task automatic test_reset();
    do_reset();
    apply(r_type(5'd3, 5'd1, 5'd2, 0), 1, 0, 0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got %b want 0", bubble); end
    checks++; if (kill_fd !== 1'b0) begin errors++; $display("FAIL reset_kill got %b want 0", kill_fd); end
    checks++; if ({fwd_a, fwd_b} !== 6'd0) begin errors++; $display("FAIL reset_fwd got %0d/%0d want 0/0", fwd_a, fwd_b); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", stall_cycles); end
    tick();
  endtask

  task automatic test_fwd_distance();
    for (int gap = 0; gap < 3; gap++) begin
      do_reset();
      apply(r_type(5'd5, 5'd1, 5'd2, 0), 1, 0, 0); tick();
      for (int k = 0; k < gap; k++) begin apply(32'h13, 1, 0, 0); tick(); end
      apply(r_type(5'd6, 5'd5, 5'd1, 0), 1, 0, 0);
      checks++; if (fwd_a !== 3'((gap < 2) ? gap + 1 : 0))
        begin errors++; $display("FAIL fwd_gap%0d fwd_a got %0d want %0d", gap, fwd_a, (gap < 2) ? gap + 1 : 0); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_gap%0d stall got %b want 0", gap, stall); end
      tick();
    end
  endtask

  task automatic test_load_use();
    do_reset();
    apply(lw(5'd5, 5'd1), 1, 0, 0); tick();
    apply(r_type(5'd6, 5'd5, 5'd5, 0), 1, 0, 0);
    checks++; if ({stall, bubble} !== 2'b11) begin errors++; $display("FAIL lu_stall stall/bubble got %b%b want 11", stall, bubble); end
    tick();
    apply(r_type(5'd6, 5'd5, 5'd5, 0), 1, 0, 0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release stall got %b want 0", stall); end
    checks++; if ({fwd_a, fwd_b} !== {3'd2, 3'd2}) begin errors++; $display("FAIL lu_fwd got %0d/%0d want 2/2", fwd_a, fwd_b); end
    checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL lu_count got %0d want 1", stall_cycles); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    apply({7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'h63}, 1, 1, 0);
    checks++; if (kill_fd !== 1'b1) begin errors++; $display("FAIL flush_c0 kill got %b want 1", kill_fd); end
    tick();
    apply(32'h0, 0, 0, 0);
    checks++; if (kill_fd !== 1'b1) begin errors++; $display("FAIL flush_c1 kill got %b want 1", kill_fd); end
    tick();
    apply(32'h0, 0, 0, 0);
    checks++; if (kill_fd !== 1'b0) begin errors++; $display("FAIL flush_c2 kill got %b want 0", kill_fd); end
    tick();
  endtask

  task automatic test_freeze();
    do_reset();
    apply(lw(5'd5, 5'd1), 1, 0, 0); tick();
    for (int k = 0; k < 3; k++) begin
      apply(r_type(5'd6, 5'd5, 5'd5, 0), 1, 1, 1);
      checks++; if ({stall, bubble, kill_fd} !== 3'b100) begin errors++; $display("FAIL freeze%0d stall/bubble/kill got %b%b%b want 100", k, stall, bubble, kill_fd); end
      checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL freeze%0d count got %0d want 0", k, stall_cycles); end
      tick();
    end
    apply(r_type(5'd6, 5'd5, 5'd5, 0), 1, 0, 0);
    checks++; if ({stall, bubble} !== 2'b11) begin errors++; $display("FAIL freeze_stall got %b%b want 11", stall, bubble); end
    tick();
    apply(r_type(5'd6, 5'd5, 5'd5, 0), 1, 0, 0);
    checks++; if ({stall, fwd_a, fwd_b} !== {1'b0, 3'd2, 3'd2}) begin errors++; $display("FAIL freeze_done stall=%b fwd=%0d/%0d want 0 2/2", stall, fwd_a, fwd_b); end
    checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL freeze_count got %0d want 1", stall_cycles); end
    tick();
  endtask

  task automatic test_x0_and_writers();
    do_reset();
    apply(addi(5'd0, 5'd0, 12'd1), 1, 0, 0); tick();
    apply(r_type(5'd1, 5'd0, 5'd0, 0), 1, 0, 0);
    checks++; if ({fwd_a, fwd_b} !== 6'd0) begin errors++; $display("FAIL x0_fwd got %0d/%0d want 0/0", fwd_a, fwd_b); end
    tick();
    do_reset();
    apply(r_type(5'd5, 5'd1, 5'd2, 0), 1, 0, 0); tick();
    apply(r_type(5'd5, 5'd3, 5'd4, 0), 1, 0, 0); tick();
    apply(r_type(5'd7, 5'd5, 5'd5, 1), 1, 0, 0);
    checks++; if ({fwd_a, fwd_b} !== {3'd1, 3'd1}) begin errors++; $display("FAIL youngest_fwd got %0d/%0d want 1/1", fwd_a, fwd_b); end
    tick();
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    apply(lw(5'd5, 5'd1), 1, 0, 0); tick();
    apply(r_type(5'd6, 5'd5, 5'd5, 0), 1, 0, 0); tick();
    apply(r_type(5'd6, 5'd5, 5'd5, 0), 1, 1, 0);
    checks++; if (kill_fd !== 1'b1) begin errors++; $display("FAIL rstflush_accept kill got %b want 1", kill_fd); end
    tick();
    do_reset();
    apply(r_type(5'd6, 5'd5, 5'd5, 0), 1, 0, 0);
    checks++; if ({kill_fd, stall} !== 2'b00) begin errors++; $display("FAIL rstflush kill/stall got %b%b want 00", kill_fd, stall); end
    checks++; if ({fwd_a, fwd_b} !== 6'd0) begin errors++; $display("FAIL rstflush_slots fwd got %0d/%0d want 0/0", fwd_a, fwd_b); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rstflush_count got %0d want 0", stall_cycles); end
    tick();
  endtask

  task automatic test_random();
    bit [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h73, 7'h37, 7'h17, 7'h6F, 7'h0B};
    bit [31:0] w;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      w = $urandom;
      w[6:0]   = ops[$urandom_range(0, 10)];
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      apply(w, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2);
      checks++; if ({stall, bubble, kill_fd} !== {e_stall, e_bubble, e_kill})
        begin errors++; $display("FAIL rnd%0d stall/bubble/kill got %b%b%b want %b%b%b", n, stall, bubble, kill_fd, e_stall, e_bubble, e_kill); end
      checks++; if (fwd_a !== 3'(e_fa) || fwd_b !== 3'(e_fb))
        begin errors++; $display("FAIL rnd%0d fwd got %0d/%0d want %0d/%0d", n, fwd_a, fwd_b, e_fa, e_fb); end
      checks++; if (stall_cycles !== 32'(m_count))
        begin errors++; $display("FAIL rnd%0d count got %0d want %0d", n, stall_cycles, m_count); end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; inst_x = '0; x_valid = 1'b0; x_redirect = 1'b0; mem_busy = 1'b0;
    test_reset();
    test_fwd_distance();
    test_load_use();
    test_flush();
    test_freeze();
    test_x0_and_writers();
    test_reset_mid_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
